fpu_norm_round: RTL and testbench

- Post-arithmetic normalize-and-round stage; sits directly downstream of the single-precision FPU datapath.
- Accepts an unnormalized sign/exponent/wide-mantissa result.
- Normalizes it with a multi-cycle shifter FSM and rounds to nearest-even.
- Emits a packed IEEE 754 single-precision word with exception flags over a valid/ready handshake.

---
 rtl/fpu_norm_round.sv | 153 +++++++++++++++
 tb/tb_fpu_norm_round.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fpu_norm_round.sv
// Normalize-and-round stage for the single-precision FPU result path.
// Left/right normalizes a wide mantissa over several cycles, rounds to nearest-even, and packs an IEEE 754 word.
module fpu_norm_round #(
    parameter int unsigned SHIFT_STEP = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [47:0] in_mant,
    input  logic        in_sticky,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] outp,
    output logic        out_ovf,
    output logic        out_unf,
    output logic        out_inexact
);

    localparam int unsigned MANT_W = 48;
    localparam int unsigned EXP_W  = 12;
    localparam int unsigned LZ_W   = 6;

    typedef enum logic [1:0] {IDLE, NORM, ROUND, HOLD} state_t;

    state_t                    state;
    logic                      sign_q;
    logic signed [EXP_W-1:0]   exp_q;
    logic [MANT_W-1:0]         mant_q;
    logic                      sticky_q;

    logic [LZ_W-1:0]           lz;
    logic [LZ_W-1:0]           shamt;
    logic                      guard;
    logic                      stk;
    logic                      rnd_up;
    logic [24:0]               kept_sum;
    logic [23:0]               kept_n;
    logic signed [EXP_W-1:0]   exp_r;
    logic [31:0]               res_outp;
    logic                      res_ovf;
    logic                      res_unf;
    logic                      res_inexact;

    // Distance from the highest set bit below bit 47 up to bit 46, clamped to one step.
    always_comb begin
        lz = '0;
        for (int i = 0; i < 47; i++) begin
            if (mant_q[i]) lz = LZ_W'(46 - i);
        end
        shamt = (lz > LZ_W'(SHIFT_STEP)) ? LZ_W'(SHIFT_STEP) : lz;
    end

    // Round to nearest-even; a carry out of 24 bits renormalizes by one.
    always_comb begin
        guard    = mant_q[22];
        stk      = (|mant_q[21:0]) | sticky_q;
        rnd_up   = guard & (stk | mant_q[23]);
        kept_sum = {1'b0, mant_q[46:23]} + 25'(rnd_up);
        if (kept_sum[24]) begin
            kept_n = kept_sum[24:1];
            exp_r  = exp_q + 12'sd1;
        end else begin
            kept_n = kept_sum[23:0];
            exp_r  = exp_q;
        end
    end

    always_comb begin
        res_outp    = {sign_q, 31'd0};
        res_ovf     = 1'b0;
        res_unf     = 1'b0;
        res_inexact = 1'b0;
        if (mant_q == '0) begin
            res_outp = {sign_q, 31'd0};
        end else if (exp_r >= 12'sd255) begin
            res_outp    = {sign_q, 8'hFF, 23'd0};
            res_ovf     = 1'b1;
            res_inexact = 1'b1;
        end else if (exp_r <= 12'sd0) begin
            res_outp    = {sign_q, 31'd0};
            res_unf     = 1'b1;
            res_inexact = 1'b1;
        end else begin
            res_outp    = {sign_q, exp_r[7:0], kept_n[22:0]};
            res_inexact = guard | stk;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            outp        <= '0;
            out_ovf     <= 1'b0;
            out_unf     <= 1'b0;
            out_inexact <= 1'b0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            sticky_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sign_q   <= in_sign;
                        exp_q    <= {{2{in_exp[9]}}, in_exp};
                        mant_q   <= in_mant;
                        sticky_q <= in_sticky;
                        in_ready <= 1'b0;
                        state    <= NORM;
                    end
                end
                NORM: begin
                    if (mant_q == '0) begin
                        state <= ROUND;
                    end else if (mant_q[47]) begin
                        mant_q   <= mant_q >> 1;
                        sticky_q <= sticky_q | mant_q[0];
                        exp_q    <= exp_q + 12'sd1;
                    end else if (mant_q[46]) begin
                        state <= ROUND;
                    end else begin
                        mant_q <= mant_q << shamt;
                        exp_q  <= exp_q - $signed(EXP_W'(shamt));
                    end
                end
                ROUND: begin
                    outp        <= res_outp;
                    out_ovf     <= res_ovf;
                    out_unf     <= res_unf;
                    out_inexact <= res_inexact;
                    out_valid   <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_norm_round.sv
// Bench for fpu_norm_round: directed corner cases plus random items checked against a value-based rounding model.
module tb_fpu_norm_round;

    localparam int STEP = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_mant;
    logic        in_sticky;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] outp;
    logic        out_ovf;
    logic        out_unf;
    logic        out_inexact;

    int checks = 0;
    int errors = 0;

    fpu_norm_round #(.SHIFT_STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_sticky(in_sticky),
        .out_valid(out_valid), .out_ready(out_ready), .outp(outp),
        .out_ovf(out_ovf), .out_unf(out_unf), .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model works from the position of the leading one, not from a shift sequence.
    function automatic logic [34:0] ref_res(input bit s, input int e, input logic [47:0] m, input bit st);
        int p;
        int ex;
        logic [63:0] k;
        bit g;
        bit r;
        if (m == 48'd0) return {s, 31'd0, 3'b000};
        p = 47;
        while (m[p] == 1'b0) p--;
        ex = e + p - 46;
        if (p >= 24) begin
            k = 64'(m) >> (p - 23);
            g = m[p-24];
            r = st || ((64'(m) & ((64'd1 << (p - 24)) - 64'd1)) != 64'd0);
        end else begin
            k = 64'(m) << (23 - p);
            g = 1'b0;
            r = st;
        end
        if (g && (r || k[0])) k = k + 64'd1;
        if (k == (64'd1 << 24)) begin
            k = 64'd1 << 23;
            ex++;
        end
        if (ex >= 255) return {s, 8'hFF, 23'd0, 3'b101};
        if (ex <= 0) return {s, 31'd0, 3'b011};
        return {s, 8'(ex), k[22:0], 2'b00, g | r};
    endfunction

    function automatic int ref_lat(input logic [47:0] m);
        int p;
        if (m == 48'd0) return 3;
        p = 47;
        while (m[p] == 1'b0) p--;
        if (p == 47) return 4;
        if (p == 46) return 3;
        return 3 + (46 - p + STEP - 1) / STEP;
    endfunction

    task automatic run_item(input bit s, input int e, input logic [47:0] m, input bit st,
                            input int hold, input logic [34:0] exp_res, input int exp_lat,
                            input string tag);
        int n;
        int lat;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/ready_in"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_sign   = s;
        in_exp    = 10'(e);
        in_mant   = m;
        in_sticky = st;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "/result"}, 64'({outp, out_ovf, out_unf, out_inexact}), 64'(exp_res));
        chk({tag, "/busy"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_mant  = 48'h0000_1234_5678;
            @(negedge clk);
            chk({tag, "/hold_result"}, 64'({outp, out_ovf, out_unf, out_inexact}), 64'(exp_res));
            chk({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "/hold_busy"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "/post_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "/post_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [47:0] m;
        int          e;
        int          sh;
        int          seen;
        bit          s;
        bit          st;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        in_sticky = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset/in_ready", 64'(in_ready), 64'd1);
        chk("reset/out_valid", 64'(out_valid), 64'd0);
        chk("reset/outp", 64'(outp), 64'd0);
        chk("reset/flags", 64'({out_ovf, out_unf, out_inexact}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_item(0, 127, 48'd1 << 46, 0, 0, {32'h3F800000, 3'b000}, 3, "one");
        run_item(0, 127, 48'd1 << 47, 0, 0, {32'h40000000, 3'b000}, 4, "right_norm");
        run_item(0, 153, 48'd1 << 20, 0, 0, {32'h3F800000, 3'b000}, 7, "left_norm");
        run_item(0, 127, (48'd1 << 46) | (48'd1 << 22), 0, 0, {32'h3F800000, 3'b001}, 3, "tie_even");
        run_item(0, 127, (48'd1 << 46) | (48'd1 << 23) | (48'd1 << 22), 0, 0,
                 {32'h3F800002, 3'b001}, 3, "tie_odd");
        run_item(0, 127, (48'd1 << 46) | (48'd1 << 22), 1, 0, {32'h3F800001, 3'b001}, 3, "tie_sticky");
        run_item(0, 127, 48'h7FFF_FFC0_0000, 0, 0, {32'h40000000, 3'b001}, 3, "carry_out");
        run_item(1, 300, 48'd1 << 46, 0, 0, {32'hFF800000, 3'b101}, 3, "overflow");
        run_item(0, 0, 48'd1 << 46, 0, 0, {32'h00000000, 3'b011}, 3, "underflow");
        run_item(1, 127, 48'd0, 0, 0, {32'h80000000, 3'b000}, 3, "zero");
        run_item(0, 130, 48'd1 << 46, 0, 10, {32'h41000000, 3'b000}, 3, "backpressure");

        // Reset while a 26-bit left shift is in progress.
        in_valid  = 1'b1;
        in_sign   = 1'b0;
        in_exp    = 10'd153;
        in_mant   = 48'd1 << 20;
        in_sticky = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset/in_ready", 64'(in_ready), 64'd1);
        chk("midreset/out_valid", 64'(out_valid), 64'd0);
        chk("midreset/outp", 64'(outp), 64'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        chk("midreset/dropped", 64'(seen), 64'd0);
        run_item(1, 128, 48'd3 << 45, 0, 0, {32'hC0400000, 3'b000}, 3, "after_reset");

        for (int n = 0; n < 150; n++) begin
            m  = {16'($urandom), $urandom};
            sh = int'($urandom_range(0, 48));
            m  = (sh == 48) ? 48'd0 : (m >> sh);
            if ($urandom_range(0, 3) == 0) begin
                m[22]   = 1'b1;
                m[21:0] = 22'd0;
            end
            e  = int'($urandom_range(0, 330)) - 20;
            s  = 1'($urandom);
            st = ($urandom_range(0, 3) == 0);
            run_item(s, e, m, st, int'($urandom_range(0, 3)), ref_res(s, e, m, st), ref_lat(m), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
